// File: rtl/uartprobe_pkg.sv
// Shared constants for the UART probe: AXI response codes, responder FSM states
// and the probe command bytes used by both host tests and the probe itself.
package uartprobe_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ADDR,
    W_DATA,
    W_RESP
  } wr_state_e;

  localparam logic [7:0] CMD_SYNC   = 8'h55;
  localparam logic [7:0] CMD_READ   = 8'h01;
  localparam logic [7:0] CMD_WRITE  = 8'h02;
  localparam logic [7:0] CMD_STATUS = 8'h03;
  localparam logic [7:0] CMD_ACK    = 8'hA0;
  localparam logic [7:0] CMD_NAK    = 8'hAF;

  // Bound is formed in 33 bits so a window ending at the top of the map never wraps.
  function automatic logic [1:0] resp_decode(input logic [31:0] addr,
                                             input logic [2:0]  size,
                                             input logic [31:0] base,
                                             input logic [32:0] depth);
    logic [32:0] lo;
    logic [32:0] hi;
    logic [32:0] a;
    lo = {1'b0, base};
    hi = lo + depth;
    a  = {1'b0, addr};
    if (size != 3'b000) return RESP_SLVERR;
    if (a < lo || a >= hi) return RESP_DECERR;
    return RESP_OKAY;
  endfunction

endpackage

// File: rtl/uartprobe_axi_resp_mem.sv
// Byte backing store for the AXI responder: one synchronous write port,
// one combinational read port, every byte reset to RESET_FILL.
module uartprobe_axi_resp_mem #(
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned AW         = 8,
  parameter logic [7:0]  RESET_FILL = 8'h00
) (
  input  logic          clk,
  input  logic          areset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= RESET_FILL;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uartprobe_axi_responder.sv
// Byte-wide AXI-lite slave terminating the probe's m_axi_* port with a small memory.
// Define UARTPROBE_AXI_RESP_WAIT_EN to add WAIT_CYCLES of stall before RVALID/BVALID.
module uartprobe_axi_responder
  import uartprobe_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH       = 256,
  parameter logic [7:0]  RESET_FILL  = 8'h00,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        areset,
  input  logic [31:0] s_axi_araddr,
  input  logic [2:0]  s_axi_arsize,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [7:0]  s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rlast,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  input  logic [31:0] s_axi_awaddr,
  input  logic [2:0]  s_axi_awsize,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [7:0]  s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wlast,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [32:0] DEPTH33 = 33'(DEPTH);

`ifdef UARTPROBE_AXI_RESP_WAIT_EN
  localparam logic [15:0] WAIT_LEN = 16'(WAIT_CYCLES);
  logic [15:0] rcnt;
  logic [15:0] wcnt;
`endif

  rd_state_e rstate;
  wr_state_e wstate;

  logic          ar_hs, aw_hs, w_hs;
  logic [1:0]    ar_resp, aw_resp_now;
  logic [AW-1:0] ar_idx, aw_idx_now;
  logic [7:0]    mem_rdata;

  logic [1:0]    aw_resp_q;
  logic [AW-1:0] aw_idx_q;
  logic [7:0]    wdata_q;
  logic          wstrb0_q;

  logic [1:0]    resp_cur;
  logic [AW-1:0] idx_cur;
  logic [7:0]    data_cur;
  logic          strb_cur;
  logic          both;
  logic          mem_we;

  logic unused_ok;
  assign unused_ok = ^{s_axi_wlast, s_axi_wstrb[3:1], (WAIT_CYCLES != 0)};

  assign ar_hs       = s_axi_arvalid & s_axi_arready;
  assign aw_hs       = s_axi_awvalid & s_axi_awready;
  assign w_hs        = s_axi_wvalid & s_axi_wready;
  assign ar_resp     = resp_decode(s_axi_araddr, s_axi_arsize, BASE_ADDR, DEPTH33);
  assign aw_resp_now = resp_decode(s_axi_awaddr, s_axi_awsize, BASE_ADDR, DEPTH33);
  assign ar_idx      = AW'(s_axi_araddr - BASE_ADDR);
  assign aw_idx_now  = AW'(s_axi_awaddr - BASE_ADDR);
  assign s_axi_rlast = s_axi_rvalid;

  // The completing handshake may be this cycle's, so take live channel values over held ones.
  always_comb begin
    resp_cur = aw_hs ? aw_resp_now : aw_resp_q;
    idx_cur  = aw_hs ? aw_idx_now : aw_idx_q;
    data_cur = w_hs ? s_axi_wdata : wdata_q;
    strb_cur = w_hs ? s_axi_wstrb[0] : wstrb0_q;
    both     = 1'b0;
    case (wstate)
      W_IDLE:  both = aw_hs & w_hs;
      W_ADDR:  both = w_hs;
      W_DATA:  both = aw_hs;
      default: both = 1'b0;
    endcase
    mem_we = both && (resp_cur == RESP_OKAY) && strb_cur;
  end

  uartprobe_axi_resp_mem #(
    .DEPTH      (DEPTH),
    .AW         (AW),
    .RESET_FILL (RESET_FILL)
  ) u_mem (
    .clk    (clk),
    .areset (areset),
    .we     (mem_we),
    .waddr  (idx_cur),
    .wdata  (data_cur),
    .raddr  (ar_idx),
    .rdata  (mem_rdata)
  );

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      rstate        <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= '0;
`ifdef UARTPROBE_AXI_RESP_WAIT_EN
      rcnt          <= '0;
`endif
    end else begin
      case (rstate)
        R_IDLE: begin
          if (ar_hs) begin
            s_axi_arready <= 1'b0;
            s_axi_rdata   <= (ar_resp == RESP_OKAY) ? mem_rdata : '0;
            s_axi_rresp   <= ar_resp;
            rstate        <= R_DATA;
`ifdef UARTPROBE_AXI_RESP_WAIT_EN
            rcnt          <= WAIT_LEN;
            s_axi_rvalid  <= (WAIT_LEN == '0);
`else
            s_axi_rvalid  <= 1'b1;
`endif
          end else begin
            s_axi_arready <= 1'b1;
          end
        end
        R_DATA: begin
`ifdef UARTPROBE_AXI_RESP_WAIT_EN
          if (!s_axi_rvalid) begin
            rcnt <= rcnt - 16'd1;
            if (rcnt == 16'd1) s_axi_rvalid <= 1'b1;
          end else
`endif
          if (s_axi_rready) begin
            s_axi_rvalid  <= 1'b0;
            s_axi_arready <= 1'b1;
            rstate        <= R_IDLE;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      wstate        <= W_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= '0;
      aw_resp_q     <= '0;
      aw_idx_q      <= '0;
      wdata_q       <= '0;
      wstrb0_q      <= 1'b0;
`ifdef UARTPROBE_AXI_RESP_WAIT_EN
      wcnt          <= '0;
`endif
    end else begin
      if (aw_hs) begin
        aw_resp_q <= aw_resp_now;
        aw_idx_q  <= aw_idx_now;
      end
      if (w_hs) begin
        wdata_q  <= s_axi_wdata;
        wstrb0_q <= s_axi_wstrb[0];
      end
      if (both) begin
        s_axi_awready <= 1'b0;
        s_axi_wready  <= 1'b0;
        s_axi_bresp   <= resp_cur;
        wstate        <= W_RESP;
`ifdef UARTPROBE_AXI_RESP_WAIT_EN
        wcnt          <= WAIT_LEN;
        s_axi_bvalid  <= (WAIT_LEN == '0);
`else
        s_axi_bvalid  <= 1'b1;
`endif
      end else begin
        case (wstate)
          W_IDLE: begin
            if (aw_hs) begin
              s_axi_awready <= 1'b0;
              s_axi_wready  <= 1'b1;
              wstate        <= W_ADDR;
            end else if (w_hs) begin
              s_axi_wready  <= 1'b0;
              s_axi_awready <= 1'b1;
              wstate        <= W_DATA;
            end else begin
              s_axi_awready <= 1'b1;
              s_axi_wready  <= 1'b1;
            end
          end
          W_ADDR: s_axi_wready  <= 1'b1;
          W_DATA: s_axi_awready <= 1'b1;
          W_RESP: begin
`ifdef UARTPROBE_AXI_RESP_WAIT_EN
            if (!s_axi_bvalid) begin
              wcnt <= wcnt - 16'd1;
              if (wcnt == 16'd1) s_axi_bvalid <= 1'b1;
            end else
`endif
            if (s_axi_bready) begin
              s_axi_bvalid  <= 1'b0;
              s_axi_awready <= 1'b1;
              s_axi_wready  <= 1'b1;
              wstate        <= W_IDLE;
            end
          end
          default: wstate <= W_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/uartprobe_axi_responder.md
Name: uartprobe_axi_responder

Overview:
Byte-wide AXI-lite-style slave that terminates the probe's narrow AXI master port (32-bit address, 8-bit data, single-beat transfers). It holds a small byte memory for bring-up, simulation and loopback, so probe commands can be exercised without real SoC fabric. It sits on the far side of the probe's m_axi_* bus.

Parameters:
BASE_ADDR, 32'h0000_0000, first byte address decoded by this block.
DEPTH, 256, number of bytes of backing store; power of two, 2..65536.
RESET_FILL, 8'h00, value every memory byte takes on reset.
WAIT_CYCLES, 0, extra stall cycles before RVALID/BVALID; used only with the optional feature.

Ports:
clk  in  1  single clock, all logic rising-edge.
areset  in  1  asynchronous, active-high reset.
s_axi_araddr  in  32  read address.
s_axi_arsize  in  3  read size; only 3'b000 is legal.
s_axi_arvalid  in  1  read address valid.
s_axi_arready  out  1  read address accept.
s_axi_rdata  out  8  read data.
s_axi_rresp  out  2  read response.
s_axi_rlast  out  1  always equals s_axi_rvalid.
s_axi_rvalid  out  1  read data valid.
s_axi_rready  in  1  read data accept.
s_axi_awaddr  in  32  write address.
s_axi_awsize  in  3  write size; only 3'b000 is legal.
s_axi_awvalid  in  1  write address valid.
s_axi_awready  out  1  write address accept.
s_axi_wdata  in  8  write data.
s_axi_wstrb  in  4  byte strobe; only bit 0 is used.
s_axi_wlast  in  1  ignored; every transfer is single-beat.
s_axi_wvalid  in  1  write data valid.
s_axi_wready  out  1  write data accept.
s_axi_bresp  out  2  write response.
s_axi_bvalid  out  1  write response valid.
s_axi_bready  in  1  write response accept.

Behaviour:
- Reset (areset high, asynchronous):
  - All valid/ready outputs go to 0; rdata=0; rresp=bresp=0.
  - Every memory byte becomes RESET_FILL.
  - Both state machines return to IDLE.
  - Any in-flight transaction is dropped with no response.
- Response decode, evaluated at address accept:
  - size!=0 -> SLVERR (2'b10), takes priority.
  - Else address outside [BASE_ADDR, BASE_ADDR+DEPTH) -> DECERR (2'b11). Compute the bound in 33 bits so no wrap occurs at 32'hFFFF_FFFF.
  - Else OKAY (2'b00).
  - Memory index is (addr-BASE_ADDR) truncated to log2(DEPTH) bits.
- Read FSM, states R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: arready=1. On arvalid, latch rdata and rresp and go to R_DATA. rvalid is asserted the next cycle (1-cycle latency).
  - rdata is forced to 8'h00 on SLVERR or DECERR.
  - R_DATA: arready=0; rvalid, rdata and rresp are held stable until rready, then return to R_IDLE. No new AR is accepted in the same cycle, so throughput is one read per 2 cycles minimum.
- Write FSM, states W_IDLE, W_ADDR (AW held), W_DATA (W held), W_RESP:
  - AW and W are accepted independently in any order or in the same cycle. awready=1 while AW is not yet held; wready=1 while W is not yet held.
  - Once both are held: commit the memory write only if OKAY and wstrb[0]=1, then enter W_RESP with bvalid=1 on the following cycle.
  - wstrb[0]=0 with OKAY gives no write and bresp OKAY.
  - W_RESP: awready=wready=0; bvalid and bresp are held until bready, then return to W_IDLE.
- Same-cycle read and write to the same byte: the read returns the old data (read-before-write); the write commits.
- Channels are otherwise fully independent. No outstanding-transaction depth beyond one per direction.

Optional Feature:
- Macro: UARTPROBE_AXI_RESP_WAIT_EN.
- Defined: a per-channel down-counter loads WAIT_CYCLES on address accept (read) or on holding both AW and W (write). rvalid/bvalid assert only after the counter reaches 0, so total latency is 1+WAIT_CYCLES. WAIT_CYCLES=0 behaves identically to undefined. Reset clears the counters.
- Undefined: no counters; WAIT_CYCLES is ignored; fixed 1-cycle latency.

Decomposition:
- Package uartprobe_pkg holds:
  - AXI response codes RESP_OKAY, RESP_SLVERR, RESP_DECERR.
  - Read and write FSM state encodings.
  - The probe command byte constants, so host tests and the probe share a single source.
- Sub-module uartprobe_axi_resp_mem: DEPTH x 8 array, one synchronous write port, one combinational read port, reset fill. The responder instantiates it once.

Test Plan:
1. Reset with RESET_FILL=8'hA5, read addr 32'h10 -> rvalid 1 cycle after AR handshake, rdata=8'hA5, rresp=00, rlast=1.
2. AW addr 32'h20 three cycles before W data 8'h3C, wstrb=1 -> bresp=00; a subsequent read of 32'h20 returns 8'h3C.
3. Read addr BASE_ADDR+DEPTH (32'h100) -> rresp=11, rdata=00. Write 32'hFFFF_FFFF -> bresp=11, memory unchanged.
4. arsize=3'b001 at addr 32'h04 -> rresp=10. Write with wstrb=0 to 32'h04 -> bresp=00, byte unchanged.
5. rready held low 10 cycles -> rvalid, rdata, rresp stable and arready=0 throughout. areset pulsed mid-R_DATA -> rvalid=0 immediately, next AR accepted normally.
6. With UARTPROBE_AXI_RESP_WAIT_EN and WAIT_CYCLES=4 -> rvalid and bvalid appear exactly 5 cycles after accept. Simultaneous read and write of 32'h08 (old 8'h11, new 8'h22) -> read returns 8'h11.
